// File: rtl/vid_pkg.sv
// Shared video timing types and constants: vertical sequencer FSM states
// and vertical sync PROM field positions.
`default_nettype none

package vid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_FETCH = 2'd2,
    ST_LATCH = 2'd3
  } vt_state_t;

  localparam int VT_BLANK_BIT = 2;
  localparam int VT_SYNC_BIT  = 1;
  localparam int VT_IRQ_BIT   = 0;

  localparam int         VLINES       = 256;
  localparam logic [7:0] VT_LAST_LINE = 8'(VLINES - 1);

endpackage

`default_nettype wire

// File: rtl/vtiming_seq_irq_latch.sv
// Interrupt request flop: set on a sampled 0->1 edge of the PROM irq bit,
// cleared by acknowledge; set takes priority over a same-cycle acknowledge.
`default_nettype none

module irq_latch (
  input  logic clk,
  input  logic reset,
  input  logic sample,
  input  logic d,
  input  logic ack,
  output logic irq
);

  logic prev_d;
  logic set;

  assign set = sample && d && !prev_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_d <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (sample) begin
        prev_d <= d;
      end
      irq <= set || (irq && !ack);
    end
  end

endmodule

`default_nettype wire

// File: rtl/vtiming_seq.sv
// Vertical timing sequencer: steps the line counter that addresses the vertical
// sync PROM and decodes the PROM's registered output into vblank/vsync/irq.
`default_nettype none

module vtiming_seq
  import vid_pkg::*;
#(
  parameter logic [7:0] VSTART     = 8'h00,
  parameter bit         OVR_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_stb,
  input  logic [3:0] prom_d,
  input  logic       irq_ack,
  output logic [7:0] prom_a,
  output logic [7:0] vcount,
  output logic       vblank,
  output logic       vsync,
  output logic       irq,
  output logic       frame_start,
  output logic       overrun
);

  vt_state_t  state;
  vt_state_t  state_nxt;
  logic [7:0] count;
  logic       pend;
  logic       count_en;
  logic       latch_en;
  logic       stb_busy;
  logic       lost;
  logic       unused_prom_bit;

  // A strobe outside IDLE must be buffered; if the buffer is full it is lost.
  assign stb_busy        = line_stb && (state != ST_IDLE);
  assign lost            = stb_busy && pend;
  assign unused_prom_bit = prom_d[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (line_stb || pend) state_nxt = ST_ADDR;
      ST_ADDR:  state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    count_en    = (state == ST_ADDR);
    latch_en    = (state == ST_LATCH);
    frame_start = count_en && (count == VT_LAST_LINE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= VSTART;
    end else if (count_en) begin
      count <= (count == VT_LAST_LINE) ? VSTART : count + 8'd1;
    end
  end

  // In IDLE the pending strobe is consumed; a coincident new strobe refills it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
    end else if (state == ST_IDLE) begin
      pend <= pend && line_stb;
    end else if (stb_busy) begin
      pend <= 1'b1;
    end
  end

  generate
    if (OVR_STICKY) begin : g_ovr_sticky
      always_ff @(posedge clk) begin
        if (reset) begin
          overrun <= 1'b0;
        end else begin
          overrun <= overrun || lost;
        end
      end
    end else begin : g_ovr_pulse
      always_ff @(posedge clk) begin
        if (reset) begin
          overrun <= 1'b0;
        end else begin
          overrun <= lost;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      vblank <= 1'b0;
      vsync  <= 1'b0;
    end else if (latch_en) begin
      vblank <= prom_d[VT_BLANK_BIT];
      vsync  <= prom_d[VT_SYNC_BIT];
    end
  end

  irq_latch u_irq_latch (
    .clk    (clk),
    .reset  (reset),
    .sample (latch_en),
    .d      (prom_d[VT_IRQ_BIT]),
    .ack    (irq_ack),
    .irq    (irq)
  );

  assign prom_a = count;
  assign vcount = count;

endmodule

`default_nettype wire
